// File: rtl/pipe_reg_bank.sv
// Inter-stage pipeline register bank (IF/ID, ID/EX, EX/MEM, MEM/WB) with sequence tagging.
// Optional performance counters are built when PIPE_REG_PERF_CNT_EN is defined.
module pipe_stage_reg #(
  parameter int DW    = 32,
  parameter int SEQ_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_bubble,
  input  logic             i_wr_en,
  input  logic             i_vld,
  input  logic [DW-1:0]    i_data,
  input  logic [SEQ_W-1:0] i_seq,
  output logic             o_vld,
  output logic [DW-1:0]    o_data,
  output logic [SEQ_W-1:0] o_seq
);
  typedef struct packed {
    logic             vld;
    logic [SEQ_W-1:0] seq;
    logic [DW-1:0]    data;
  } stg_t;

  stg_t r_stg;

  // bubble beats load, load beats hold
  always_ff @(posedge clk) begin
    if (reset || i_bubble) r_stg <= '0;
    else if (i_wr_en)      r_stg <= '{vld: i_vld, seq: i_seq, data: i_data};
  end

  assign o_vld  = r_stg.vld;
  assign o_data = r_stg.data;
  assign o_seq  = r_stg.seq;
endmodule

module pipe_reg_bank #(
  parameter int DW    = 32,
  parameter int SEQ_W = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             if_valid,
  input  logic [DW-1:0]    if_data,
  input  logic             if_bubble,
  input  logic             id_bubble,
  input  logic             ex_bubble,
  input  logic             mem_bubble,
  input  logic             wb_bubble,
  input  logic             id_wr_en,
  input  logic             ex_wr_en,
  input  logic             mem_wr_en,
  input  logic             wb_wr_en,
  input  logic [DW-1:0]    id_nxt,
  input  logic [DW-1:0]    ex_nxt,
  input  logic [DW-1:0]    mem_nxt,
  output logic             id_valid,
  output logic             ex_valid,
  output logic             mem_valid,
  output logic             wb_valid,
  output logic [DW-1:0]    id_data,
  output logic [DW-1:0]    ex_data,
  output logic [DW-1:0]    mem_data,
  output logic [DW-1:0]    wb_data,
  output logic [SEQ_W-1:0] id_seq,
  output logic [SEQ_W-1:0] ex_seq,
  output logic [SEQ_W-1:0] mem_seq,
  output logic [SEQ_W-1:0] wb_seq,
  output logic             retire,
  output logic [SEQ_W-1:0] retire_seq,
  output logic [CNT_W-1:0] perf_bubbles,
  output logic [CNT_W-1:0] perf_stalls,
  output logic [CNT_W-1:0] perf_retired
);
  localparam int NSTG = 4;

  logic [NSTG-1:0]            w_bub, w_wr, w_up_vld, w_vld;
  logic [NSTG-1:0][DW-1:0]    w_up_data, w_data;
  logic [NSTG-1:0][SEQ_W-1:0] w_up_seq, w_seq;
  logic [SEQ_W-1:0]           r_tag;

  assign w_bub     = {wb_bubble, mem_bubble, ex_bubble, id_bubble};
  assign w_wr      = {wb_wr_en, mem_wr_en, ex_wr_en, id_wr_en};
  assign w_up_vld  = {w_vld[2:0], if_valid & ~if_bubble};
  assign w_up_data = {mem_nxt, ex_nxt, id_nxt, if_data};
  assign w_up_seq  = {w_seq[2:0], r_tag};

  for (genvar g = 0; g < NSTG; g++) begin : g_stg
    pipe_stage_reg #(.DW(DW), .SEQ_W(SEQ_W)) u_stg (
      .clk      (clk),
      .reset    (reset),
      .i_bubble (w_bub[g]),
      .i_wr_en  (w_wr[g]),
      .i_vld    (w_up_vld[g]),
      .i_data   (w_up_data[g]),
      .i_seq    (w_up_seq[g]),
      .o_vld    (w_vld[g]),
      .o_data   (w_data[g]),
      .o_seq    (w_seq[g])
    );
  end

  // tag advances only when a live fetch actually lands in IF/ID
  always_ff @(posedge clk) begin
    if (reset)                                   r_tag <= '0;
    else if (!id_bubble && id_wr_en && w_up_vld[0]) r_tag <= r_tag + SEQ_W'(1);
  end

  assign {wb_valid, mem_valid, ex_valid, id_valid} = w_vld;
  assign id_data  = w_data[0];
  assign ex_data  = w_data[1];
  assign mem_data = w_data[2];
  assign wb_data  = w_data[3];
  assign id_seq   = w_seq[0];
  assign ex_seq   = w_seq[1];
  assign mem_seq  = w_seq[2];
  assign wb_seq   = w_seq[3];

  assign retire     = wb_valid & wb_wr_en & ~wb_bubble;
  assign retire_seq = wb_seq;

`ifdef PIPE_REG_PERF_CNT_EN
  logic             w_bub_evt, w_stall_evt;
  logic [CNT_W-1:0] r_perf_bub, r_perf_stall, r_perf_ret;

  assign w_bub_evt   = ex_bubble | mem_bubble | wb_bubble;
  assign w_stall_evt = ~id_wr_en & ~id_bubble;

  // saturating event counters
  always_ff @(posedge clk) begin
    if (reset) begin
      r_perf_bub   <= '0;
      r_perf_stall <= '0;
      r_perf_ret   <= '0;
    end else begin
      if (w_bub_evt   && r_perf_bub   != '1) r_perf_bub   <= r_perf_bub   + CNT_W'(1);
      if (w_stall_evt && r_perf_stall != '1) r_perf_stall <= r_perf_stall + CNT_W'(1);
      if (retire      && r_perf_ret   != '1) r_perf_ret   <= r_perf_ret   + CNT_W'(1);
    end
  end

  assign perf_bubbles = r_perf_bub;
  assign perf_stalls  = r_perf_stall;
  assign perf_retired = r_perf_ret;
`else
  assign perf_bubbles = '0;
  assign perf_stalls  = '0;
  assign perf_retired = '0;
`endif
endmodule

// File: tb/tb_pipe_reg_bank.sv
// Directed bench for pipe_reg_bank: streaming, stall, bubbles, squash, tag wrap, reset override.
// Perf counters use a narrow CNT_W so saturation is reachable.
module tb_pipe_reg_bank;
  localparam int DW = 32, SEQ_W = 8, CNT_W = 4;
`ifdef PIPE_REG_PERF_CNT_EN
  localparam int PEN = -1;
`else
  localparam int PEN = 0;
`endif

  logic clk = 1'b0, reset;
  logic if_valid, if_bubble, id_bubble, ex_bubble, mem_bubble, wb_bubble;
  logic id_wr_en, ex_wr_en, mem_wr_en, wb_wr_en;
  logic [DW-1:0] if_data, id_nxt, ex_nxt, mem_nxt;
  logic id_valid, ex_valid, mem_valid, wb_valid, retire;
  logic [DW-1:0] id_data, ex_data, mem_data, wb_data;
  logic [SEQ_W-1:0] id_seq, ex_seq, mem_seq, wb_seq, retire_seq;
  logic [CNT_W-1:0] perf_bubbles, perf_stalls, perf_retired;

  int n_cmp = 0, n_err = 0, cyc = 0;

  always #5 clk = ~clk;

  pipe_reg_bank #(.DW(DW), .SEQ_W(SEQ_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .if_valid(if_valid), .if_data(if_data), .if_bubble(if_bubble),
    .id_bubble(id_bubble), .ex_bubble(ex_bubble), .mem_bubble(mem_bubble), .wb_bubble(wb_bubble),
    .id_wr_en(id_wr_en), .ex_wr_en(ex_wr_en), .mem_wr_en(mem_wr_en), .wb_wr_en(wb_wr_en),
    .id_nxt(id_nxt), .ex_nxt(ex_nxt), .mem_nxt(mem_nxt),
    .id_valid(id_valid), .ex_valid(ex_valid), .mem_valid(mem_valid), .wb_valid(wb_valid),
    .id_data(id_data), .ex_data(ex_data), .mem_data(mem_data), .wb_data(wb_data),
    .id_seq(id_seq), .ex_seq(ex_seq), .mem_seq(mem_seq), .wb_seq(wb_seq),
    .retire(retire), .retire_seq(retire_seq),
    .perf_bubbles(perf_bubbles), .perf_stalls(perf_stalls), .perf_retired(perf_retired)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int pexp(input int v);
    return v & PEN;
  endfunction

  // stage payloads are tagged with the cycle they were presented in
  task automatic tick();
    id_nxt  = 32'h1000 + cyc;
    ex_nxt  = 32'h2000 + cyc;
    mem_nxt = 32'h3000 + cyc;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic ctl(input logic idw, input logic exw, input logic memw, input logic wbw);
    id_wr_en = idw; ex_wr_en = exw; mem_wr_en = memw; wb_wr_en = wbw;
  endtask

  int c5, exp_rs, nret;

  initial begin
    reset = 1'b1; if_valid = 1'b1; if_data = 32'hDEAD;
    if_bubble = 1'b0; id_bubble = 1'b0; ex_bubble = 1'b0; mem_bubble = 1'b0; wb_bubble = 1'b0;
    ctl(1, 1, 1, 1);
    tick(); tick();
    chk("rst_vld", 32'({id_valid, ex_valid, mem_valid, wb_valid}), 0);
    chk("rst_seq", 32'({id_seq, ex_seq, mem_seq, wb_seq}), 0);
    chk("rst_data", 32'(id_data | ex_data | mem_data | wb_data), 0);
    chk("rst_retire", 32'(retire), 0);
    chk("rst_perf", 32'({perf_bubbles, perf_stalls, perf_retired}), 0);

    // streaming: fetch k presented before tick k
    reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if_data = 32'hA00 + k;
      tick();
      chk("str_id_seq", 32'(id_seq), k);
      chk("str_id_data", id_data, 32'hA00 + k);
      chk("str_retire", 32'(retire), (k >= 3) ? 1 : 0);
      if (k >= 3) chk("str_retire_seq", 32'(retire_seq), k - 3);
      if (k == 0) chk("str_ex_vld0", 32'(ex_valid), 0);
    end
    c5 = cyc - 1;
    chk("str_ex_data", ex_data, 32'h1000 + c5);
    chk("str_wb_seq", 32'(wb_seq), 2);

    // IF/ID and ID/EX frozen for 3 cycles
    ctl(0, 0, 1, 1);
    for (int k = 0; k < 3; k++) begin
      if_data = 32'hBAD0 + k;
      tick();
    end
    chk("stl_id_seq", 32'(id_seq), 5);
    chk("stl_id_data", id_data, 32'hA05);
    chk("stl_ex_seq", 32'(ex_seq), 4);
    chk("stl_ex_data", ex_data, 32'h1000 + c5);
    chk("stl_mem_seq", 32'(mem_seq), 4);
    chk("stl_mem_data", mem_data, 32'h2000 + cyc - 1);
    chk("stl_perf_stalls", 32'(perf_stalls), pexp(3));
    chk("stl_perf_bub", 32'(perf_bubbles), pexp(0));
    chk("stl_perf_ret", 32'(perf_retired), pexp(5));

    // resume: tag must not have moved during the stall
    ctl(1, 1, 1, 1);
    if_data = 32'hA06;
    tick();
    chk("res_id_seq", 32'(id_seq), 6);
    chk("res_id_data", id_data, 32'hA06);
    chk("res_ex_seq", 32'(ex_seq), 5);
    chk("res_perf_ret", 32'(perf_retired), pexp(6));

    // ex bubble with load enabled
    ex_bubble = 1'b1; if_data = 32'hA07;
    tick();
    chk("exb_ex_vld", 32'(ex_valid), 0);
    chk("exb_ex_data", ex_data, 0);
    chk("exb_ex_seq", 32'(ex_seq), 0);
    chk("exb_mem_seq", 32'(mem_seq), 5);
    chk("exb_id_seq", 32'(id_seq), 7);
    chk("exb_perf_bub", 32'(perf_bubbles), pexp(1));

    // mem bubble wins over mem_wr_en=0; no fetch
    ex_bubble = 1'b0; mem_bubble = 1'b1; mem_wr_en = 1'b0; if_valid = 1'b0;
    tick();
    chk("memb_mem_vld", 32'(mem_valid), 0);
    chk("memb_mem_data", mem_data, 0);
    chk("memb_id_vld", 32'(id_valid), 0);
    chk("memb_ex_vld", 32'(ex_valid), 1);
    chk("memb_ex_seq", 32'(ex_seq), 7);
    chk("memb_perf_bub", 32'(perf_bubbles), pexp(2));

    // squashed fetch
    mem_bubble = 1'b0; mem_wr_en = 1'b1; if_valid = 1'b1; if_bubble = 1'b1; if_data = 32'hA08;
    tick();
    chk("sq_id_vld", 32'(id_valid), 0);
    chk("sq_id_seq", 32'(id_seq), 8);
    if_bubble = 1'b0; if_data = 32'hA09;
    tick();
    chk("sq_next_vld", 32'(id_valid), 1);
    chk("sq_next_seq", 32'(id_seq), 8);
    chk("sq_next_data", id_data, 32'hA09);
    chk("pre_rst_stalls", 32'(perf_stalls), pexp(3));

    // reset while stalled and bubbling
    ctl(0, 0, 1, 1); mem_bubble = 1'b1; reset = 1'b1;
    tick();
    chk("mrst_vld", 32'({id_valid, ex_valid, mem_valid, wb_valid}), 0);
    chk("mrst_seq", 32'({id_seq, ex_seq, mem_seq, wb_seq}), 0);
    chk("mrst_data", id_data, 0);
    chk("mrst_retire", 32'(retire), 0);
    chk("mrst_perf", 32'({perf_bubbles, perf_stalls, perf_retired}), 0);

    // 300 fetches across the tag wrap
    reset = 1'b0; mem_bubble = 1'b0; ctl(1, 1, 1, 1);
    exp_rs = 0; nret = 0;
    for (int k = 0; k < 300; k++) begin
      if_data = k;
      tick();
      if (k >= 254 && k <= 257) chk("wrap_id_seq", 32'(id_seq), k & 255);
      if (retire) begin
        chk("wrap_retire_seq", 32'(retire_seq), exp_rs & 255);
        exp_rs++; nret++;
      end
    end
    chk("wrap_nret", nret, 297);
    chk("wrap_perf_ret_sat", 32'(perf_retired), pexp(15));
    chk("wrap_perf_stalls", 32'(perf_stalls), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
